// File: rtl/rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter4
// Description : Four-requester round-robin arbiter with enable and an
//               optional per-tenure hold limit. It grants one shared
//               resource to requesters 0..3. The grant is given both as a
//               one-hot vector and as an encoded index.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   MAX_HOLD  - maximum consecutive grant cycles per tenure (0 = unlimited)
//   CNT_W     - hold-counter width; 2**CNT_W must exceed MAX_HOLD
// Ports:
//   clk       in   1  rising-edge clock
//   rst       in   1  synchronous reset, active-high
//   e         in   1  arbiter enable
//   req       in   4  level-sensitive request vector, bit n = requester n
//   gnt       out  4  registered one-hot grant (or zero)
//   gnt_id    out  2  registered winner index, meaningful when gnt_valid=1
//   gnt_valid out  1  registered, equals |gnt
//   preempt   out  1  one-cycle pulse when a tenure is cut by the hold limit
// ============================================================================
module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       e,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       preempt
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] C_MAX_HOLD = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] C_CNT_SAT  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
  localparam logic             C_LIMIT_EN = (MAX_HOLD != 0);

  // --------------------------------------------------------------------------
  // Registered state and outputs
  // --------------------------------------------------------------------------
  state_t           state_q;
  logic [3:0]       gnt_q;
  logic [1:0]       gnt_id_q;
  logic             gnt_valid_q;
  logic             preempt_q;
  logic [1:0]       ptr_q;
  logic [CNT_W-1:0] hold_cnt_q;

  // --------------------------------------------------------------------------
  // Combinational arbitration
  // --------------------------------------------------------------------------
  logic [1:0] w_start;
  logic [1:0] w_win_ofs;
  logic [1:0] w_win;
  logic       w_found;
  logic       w_holder_req;
  logic       w_limit_hit;

  // While a tenure is running, every way of ending it (release or limit)
  // moves the pointer to holder+1 and re-arbitrates from there, so the
  // search start is holder+1. A releasing holder has req[h]=0 and therefore
  // drops out naturally; a pre-empted holder is still requesting but sits
  // last in the search order, which is exactly the required fairness.
  always_comb begin
    w_start   = (state_q == S_GRANT) ? (gnt_id_q + 2'd1) : ptr_q;
    w_found   = |req;
    w_win_ofs = 2'd0;
    // Walk offsets from the far end so the closest set bit wins last.
    for (int k = 3; k >= 0; k--) begin
      if (req[w_start + 2'(k)]) begin
        w_win_ofs = 2'(k);
      end
    end
    w_win        = w_start + w_win_ofs;
    w_holder_req = req[gnt_id_q];
    w_limit_hit  = C_LIMIT_EN && (hold_cnt_q == C_MAX_HOLD);
  end

  // --------------------------------------------------------------------------
  // Arbiter state machine with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gnt_q       <= 4'b0000;
      gnt_id_q    <= 2'd0;
      gnt_valid_q <= 1'b0;
      preempt_q   <= 1'b0;
      ptr_q       <= 2'd0;
      hold_cnt_q  <= '0;
    end else begin
      // The pre-emption pulse lasts exactly one cycle unless re-asserted.
      preempt_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (e && w_found) begin
            state_q     <= S_GRANT;
            gnt_q       <= 4'b0001 << w_win;
            gnt_id_q    <= w_win;
            gnt_valid_q <= 1'b1;
            hold_cnt_q  <= C_CNT_ONE;
          end else begin
            state_q     <= S_IDLE;
            gnt_q       <= 4'b0000;
            gnt_id_q    <= 2'd0;
            gnt_valid_q <= 1'b0;
            hold_cnt_q  <= '0;
          end
        end

        S_GRANT: begin
          if (!e) begin
            // Disabled: drop the grant, next tenure starts after the holder.
            state_q     <= S_IDLE;
            gnt_q       <= 4'b0000;
            gnt_id_q    <= 2'd0;
            gnt_valid_q <= 1'b0;
            hold_cnt_q  <= '0;
            ptr_q       <= gnt_id_q + 2'd1;
          end else if (!w_holder_req) begin
            // Voluntary release: hand over back-to-back if anyone waits.
            ptr_q <= gnt_id_q + 2'd1;
            if (w_found) begin
              state_q     <= S_GRANT;
              gnt_q       <= 4'b0001 << w_win;
              gnt_id_q    <= w_win;
              gnt_valid_q <= 1'b1;
              hold_cnt_q  <= C_CNT_ONE;
            end else begin
              state_q     <= S_IDLE;
              gnt_q       <= 4'b0000;
              gnt_id_q    <= 2'd0;
              gnt_valid_q <= 1'b0;
              hold_cnt_q  <= '0;
            end
          end else if (w_limit_hit) begin
            // Hold limit reached while still requesting. The holder keeps
            // req high, so a winner always exists (possibly the holder).
            preempt_q   <= 1'b1;
            ptr_q       <= gnt_id_q + 2'd1;
            state_q     <= S_GRANT;
            gnt_q       <= 4'b0001 << w_win;
            gnt_id_q    <= w_win;
            gnt_valid_q <= 1'b1;
            hold_cnt_q  <= C_CNT_ONE;
          end else begin
            // Keep the grant; the counter saturates instead of wrapping so
            // an unlimited tenure can never alias back onto the limit.
            if (hold_cnt_q != C_CNT_SAT) begin
              hold_cnt_q <= hold_cnt_q + C_CNT_ONE;
            end
          end
        end

        default: begin
          state_q     <= S_IDLE;
          gnt_q       <= 4'b0000;
          gnt_id_q    <= 2'd0;
          gnt_valid_q <= 1'b0;
          hold_cnt_q  <= '0;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign preempt   = preempt_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arbiter4
// Description : Self-checking bench for rr_arbiter4. Three instances with
//               MAX_HOLD = 1, 8 and 0 share one stimulus stream. A
//               behavioural model (holder index, pointer and tenure length
//               as plain integers) predicts every instance each cycle.
//               Directed scenarios add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter4;

  logic       clk = 1'b0;
  logic       rst;
  logic       e;
  logic [3:0] req;

  logic [3:0] d_gnt   [3];
  logic [1:0] d_id    [3];
  logic       d_valid [3];
  logic       d_pre   [3];

  always #5 clk = ~clk;

  rr_arbiter4 #(.MAX_HOLD(1), .CNT_W(4)) u_dut_h1 (
    .clk(clk), .rst(rst), .e(e), .req(req),
    .gnt(d_gnt[0]), .gnt_id(d_id[0]), .gnt_valid(d_valid[0]), .preempt(d_pre[0])
  );
  rr_arbiter4 #(.MAX_HOLD(8), .CNT_W(4)) u_dut_h8 (
    .clk(clk), .rst(rst), .e(e), .req(req),
    .gnt(d_gnt[1]), .gnt_id(d_id[1]), .gnt_valid(d_valid[1]), .preempt(d_pre[1])
  );
  rr_arbiter4 #(.MAX_HOLD(0), .CNT_W(4)) u_dut_h0 (
    .clk(clk), .rst(rst), .e(e), .req(req),
    .gnt(d_gnt[2]), .gnt_id(d_id[2]), .gnt_valid(d_valid[2]), .preempt(d_pre[2])
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // --------------------------------------------------------------------------
  // Behavioural model: who holds the grant (-1 = nobody), where the next
  // search starts, and how many cycles the current tenure has lasted.
  // --------------------------------------------------------------------------
  int lim     [3] = '{1, 8, 0};
  int m_holder[3] = '{-1, -1, -1};
  int m_ptr   [3] = '{0, 0, 0};
  int m_cnt   [3] = '{0, 0, 0};
  bit m_pre   [3] = '{1'b0, 1'b0, 1'b0};
  int m_h;

  function automatic int pick(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      m_h      = m_holder[i];
      m_pre[i] = 1'b0;
      if (rst) begin
        m_holder[i] = -1;
        m_ptr[i]    = 0;
        m_cnt[i]    = 0;
      end else if (m_h < 0) begin
        if (e && req != 4'b0000) begin
          m_holder[i] = pick(req, m_ptr[i]);
          m_cnt[i]    = 1;
        end
      end else if (!e) begin
        m_holder[i] = -1;
        m_ptr[i]    = (m_h + 1) % 4;
      end else if (!req[m_h]) begin
        m_ptr[i]    = (m_h + 1) % 4;
        m_holder[i] = pick(req, m_ptr[i]);
        m_cnt[i]    = 1;
      end else if (lim[i] != 0 && m_cnt[i] == lim[i]) begin
        m_pre[i]    = 1'b1;
        m_ptr[i]    = (m_h + 1) % 4;
        m_holder[i] = pick(req, m_ptr[i]);
        m_cnt[i]    = 1;
      end else begin
        m_cnt[i] = (m_cnt[i] < 15) ? m_cnt[i] + 1 : 15;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-cycle comparison of every instance against the model
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        logic [3:0] xg;
        logic       xv;
        logic [1:0] xid;
        bit         bad;
        xv  = (m_holder[i] >= 0);
        xg  = xv ? (4'b0001 << m_holder[i]) : 4'b0000;
        xid = xv ? 2'(m_holder[i]) : 2'd0;
        bad = (d_gnt[i] !== xg) || (d_valid[i] !== xv) || (d_pre[i] !== m_pre[i]) ||
              (xv && (d_id[i] !== xid));
        n_cmp++;
        if (bad) begin
          n_bad++;
          $display("FAIL model_cmp[lim=%0d] t=%0t: got gnt=%b id=%0d v=%b p=%b, expected gnt=%b id=%0d v=%b p=%b",
                   lim[i], $time, d_gnt[i], d_id[i], d_valid[i], d_pre[i], xg, xid, xv, m_pre[i]);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic step(input logic r, input logic en, input logic [3:0] q);
    rst = r;
    e   = en;
    req = q;
    @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    e   = 1'b0;
    req = 4'b0000;
    @(negedge clk);
    chk_en = 1'b1;

    // Reset state and single request
    step(1'b1, 1'b0, 4'b0000);
    check("rst_gnt",     int'(d_gnt[1]),   0);
    check("rst_id",      int'(d_id[1]),    0);
    check("rst_valid",   int'(d_valid[1]), 0);
    check("rst_preempt", int'(d_pre[1]),   0);
    step(1'b0, 1'b1, 4'b0100);
    check("single_gnt",   int'(d_gnt[1]),   4'b0100);
    check("single_id",    int'(d_id[1]),    2);
    check("single_valid", int'(d_valid[1]), 1);
    step(1'b0, 1'b1, 4'b0000);
    check("single_drop", int'(d_gnt[1]), 0);

    // Rotation with MAX_HOLD=1
    step(1'b1, 1'b0, 4'b0000);
    begin
      logic [3:0] rot_exp [5];
      rot_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      for (int i = 0; i < 5; i++) begin
        step(1'b0, 1'b1, 4'b1111);
        check($sformatf("rot_gnt[%0d]", i), int'(d_gnt[0]), int'(rot_exp[i]));
        check($sformatf("rot_pre[%0d]", i), int'(d_pre[0]), (i == 0) ? 0 : 1);
      end
    end

    // Back-to-back release
    step(1'b1, 1'b0, 4'b0000);
    step(1'b0, 1'b1, 4'b0010);
    check("b2b_hold1", int'(d_gnt[1]), 4'b0010);
    step(1'b0, 1'b1, 4'b0011);
    check("b2b_hold2", int'(d_gnt[1]), 4'b0010);
    step(1'b0, 1'b1, 4'b0001);
    check("b2b_next", int'(d_gnt[1]), 4'b0001);
    check("b2b_valid", int'(d_valid[1]), 1);

    // Hold limit, two requesters
    step(1'b1, 1'b0, 4'b0000);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 4'b0101);
      check($sformatf("lim_a_gnt[%0d]", i), int'(d_gnt[1]), 4'b0001);
      check($sformatf("lim_a_pre[%0d]", i), int'(d_pre[1]), 0);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 4'b0101);
      check($sformatf("lim_b_gnt[%0d]", i), int'(d_gnt[1]), 4'b0100);
      check($sformatf("lim_b_pre[%0d]", i), int'(d_pre[1]), (i == 0) ? 1 : 0);
    end
    step(1'b0, 1'b1, 4'b0101);
    check("lim_back_gnt", int'(d_gnt[1]), 4'b0001);
    check("lim_back_pre", int'(d_pre[1]), 1);

    // Hold limit, sole requester is re-granted with a pulse every 8 cycles
    step(1'b1, 1'b0, 4'b0000);
    for (int i = 0; i < 17; i++) begin
      step(1'b0, 1'b1, 4'b0001);
      check($sformatf("solo_gnt[%0d]", i), int'(d_gnt[1]), 4'b0001);
      check($sformatf("solo_pre[%0d]", i), int'(d_pre[1]), (i == 8 || i == 16) ? 1 : 0);
    end

    // Enable and reset mid-tenure
    step(1'b1, 1'b0, 4'b0000);
    step(1'b0, 1'b1, 4'b1000);
    check("en_holder3", int'(d_gnt[1]), 4'b1000);
    step(1'b0, 1'b0, 4'b1000);
    check("en_drop", int'(d_gnt[1]), 0);
    step(1'b0, 1'b1, 4'b1001);
    check("en_reenable", int'(d_gnt[1]), 4'b0001);
    step(1'b0, 1'b1, 4'b1000);
    check("en_to3", int'(d_gnt[1]), 4'b1000);
    step(1'b1, 1'b1, 4'b1000);
    check("midrst_gnt", int'(d_gnt[1]), 0);
    check("midrst_valid", int'(d_valid[1]), 0);
    step(1'b0, 1'b1, 4'b1001);
    check("midrst_ptr0", int'(d_gnt[1]), 4'b0001);

    // Unlimited hold
    step(1'b1, 1'b0, 4'b0000);
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, 4'b0010);
      check($sformatf("unl_gnt[%0d]", i), int'(d_gnt[2]), 4'b0010);
      check($sformatf("unl_pre[%0d]", i), int'(d_pre[2]), 0);
    end

    // Randomised traffic against the model
    step(1'b1, 1'b0, 4'b0000);
    begin
      logic [3:0] rq;
      rq = 4'(($urandom_range(0, 15)));
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 3) == 0) rq = rq ^ 4'($urandom_range(0, 15));
        step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
             ($urandom_range(0, 19) != 0) ? 1'b1 : 1'b0,
             rq);
      end
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
